// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execute stage.
//   - ALU operation codes carried in the control bus op field
//   - control bus bit positions
//   - funct3 store-size encodings
//   - execute-stage FSM state type
package exec_pkg;

  // ALU op field encodings
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_MUL  = 4'hA;

  // Control bus layout; bits not listed here pass through untouched
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_ALUSRC   = 3;

  // funct3 store sizes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } exec_state_e;

  // Shift-amount width: 5 bits for RV32, 6 bits for RV64
  function automatic int shamt_w(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-add multiplier returning the low XLEN bits of a*b.
//   clk1       clock
//   rst        synchronous active-high reset
//   i_start    latch operands and begin iterating
//   i_abort    drop the product in progress
//   i_a, i_b   operands (low product bits are sign-agnostic)
//   o_done     high during the final step; o_product is valid then
//   o_product  low XLEN bits of the product
// One step per cycle for XLEN cycles; o_done is asserted combinationally
// on the last step so the caller can register the product on that edge.
module seq_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            r_run;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;   // shifts left each step
  logic [XLEN-1:0] r_mplier;  // shifts right; bit 0 selects the add

  logic [XLEN-1:0] w_addend;
  logic [XLEN-1:0] w_acc_nxt;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;
  assign o_done    = r_run && (r_cnt == LAST);
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_abort) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_run) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: RISC-V execute stage between register-read and memory.
//   clk1, rst            clock, synchronous active-high reset
//   flush                kill in-flight MUL and output register contents
//   in_valid / in_ready  upstream handshake
//   rd1, rd2, imm        operand A, register operand B / store source, immediate
//   instr, ctrl_in       instruction word and decoded control bus
//   out_valid/out_ready  downstream handshake
//   result, store_data   ALU/MUL result and size-formatted store data
//   instr_out, ctrl_out  registered instruction and control bus
//   busy                 iterative multiplier running (upstream stalled)
// Non-MUL ops complete in one cycle. MUL ops (ENABLE_MUL=1) latch into
// seq_mul and complete XLEN+1 cycles after accept.
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CTRL_W     = 8,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic [XLEN-1:0]   imm,
  input  logic [31:0]       instr,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic [XLEN-1:0]   store_data,
  output logic [31:0]       instr_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              busy
);

  localparam int SHW = shamt_w(XLEN);

  exec_state_e       r_state;
  logic              r_busy;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_store;
  logic [31:0]       r_instr;
  logic [CTRL_W-1:0] r_ctrl;

  logic [3:0]        w_op;
  logic [XLEN-1:0]   w_srcb;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_sd;
  logic [XLEN-1:0]   w_zx32;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_done;
  logic [XLEN-1:0]   w_mul_prod;

  assign w_op    = ctrl_in[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign w_srcb  = ctrl_in[CTRL_ALUSRC] ? imm : rd2;
  assign w_shamt = w_srcb[SHW-1:0];

  // Only routed to the multiplier when it exists; otherwise MUL falls into
  // the single-cycle path and produces 0.
  assign w_is_mul = (ENABLE_MUL != 0) && (w_op == ALU_MUL);

  assign w_in_ready = !r_busy && (!r_out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && w_in_ready;

  // ALU
  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_ADD:  w_alu = rd1 + w_srcb;
      ALU_SUB:  w_alu = rd1 - w_srcb;
      ALU_AND:  w_alu = rd1 & w_srcb;
      ALU_OR:   w_alu = rd1 | w_srcb;
      ALU_XOR:  w_alu = rd1 ^ w_srcb;
      ALU_SLT:  w_alu[0] = $signed(rd1) < $signed(w_srcb);
      ALU_SLTU: w_alu[0] = rd1 < w_srcb;
      ALU_SLL:  w_alu = rd1 << w_shamt;
      ALU_SRL:  w_alu = rd1 >> w_shamt;
      ALU_SRA:  w_alu = $unsigned($signed(rd1) >>> w_shamt);
      default:  w_alu = '0;  // MUL and unused codes
    endcase
  end

  // Store formatting; unknown sizes pass rd2 through so nothing stale leaks
  always_comb begin
    w_zx32        = '0;
    w_zx32[31:0]  = rd2[31:0];
    w_sd          = rd2;
    case (instr[14:12])
      F3_SB: begin
        w_sd      = '0;
        w_sd[7:0] = rd2[7:0];
      end
      F3_SH: begin
        w_sd       = '0;
        w_sd[15:0] = rd2[15:0];
      end
      F3_SW:   w_sd = w_zx32;
      F3_SD:   w_sd = (XLEN == 64) ? rd2 : w_zx32;
      default: w_sd = rd2;
    endcase
  end

  generate
    if (ENABLE_MUL != 0) begin : g_mul
      seq_mul #(.XLEN(XLEN)) u_mul (
        .clk1      (clk1),
        .rst       (rst),
        .i_start   (w_accept && w_is_mul),
        .i_abort   (flush),
        .i_a       (rd1),
        .i_b       (w_srcb),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
      );
    end else begin : g_nomul
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  // Stage FSM and output register. A MUL accept loads store data, instr
  // and ctrl straight into the output register (don't-care while
  // out_valid=0); only result waits for the multiplier.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_store     <= '0;
      r_instr     <= '0;
      r_ctrl      <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_store <= w_sd;
            r_instr <= instr;
            r_ctrl  <= ctrl_in;
            if (w_is_mul) begin
              r_state     <= MUL_RUN;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_result    <= w_alu;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        MUL_RUN: begin
          if (w_mul_done) begin
            r_result    <= w_mul_prod;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign store_data = r_store;
  assign instr_out  = r_instr;
  assign ctrl_out   = r_ctrl;
  assign busy       = r_busy;

endmodule
